uart_reg_bridge: RTL and testbench

//  Byte-level register bridge between the UART RX/TX byte interfaces and the R-peak detection core.

---
 rtl/uart_reg_bridge.sv | 172 +++++++++++++++++
 tb/tb_uart_reg_bridge.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_bridge.sv
// Byte-level register bridge between the UART byte interfaces and the R-peak core.
// Host commands are {4'b0, addr[2:0], wr}. Writes assemble ECG samples; reads drain a small R-peak FIFO.
module uart_reg_bridge #(
  parameter int DATA_WIDTH  = 11,
  parameter int CTR_WIDTH   = 22,
  parameter int DATA_OFFSET = 1024,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx_data_valid,
  input  logic [7:0]                   rx_data,
  input  logic                         tx_busy,
  output logic                         tx_data_valid,
  output logic [7:0]                   tx_data,
  output logic signed [DATA_WIDTH-1:0] sample_out,
  output logic                         sample_valid,
  input  logic [CTR_WIDTH-1:0]         rpeak_loc,
  input  logic                         rpeak_valid
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int HOLD_W = 24;

  localparam logic [2:0] ADDR_SR    = 3'd0;
  localparam logic [2:0] ADDR_DINL  = 3'd1;
  localparam logic [2:0] ADDR_DINH  = 3'd2;
  localparam logic [2:0] ADDR_DOUTL = 3'd3;
  localparam logic [2:0] ADDR_DOUTM = 3'd4;
  localparam logic [2:0] ADDR_DOUTH = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    WR_DATA,
    RD_RESP
  } state_t;

  state_t              state;
  logic [2:0]          addr;
  logic [7:0]          dinl;
  logic [HOLD_W-1:0]   hold;
  logic                cmd_err;
  logic                overflow;

  logic [CTR_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [CNT_W-1:0]     count;

  logic              fifo_empty;
  logic              fifo_full;
  logic              send;
  logic              pop;
  logic              push;
  logic              drop;
  logic [HOLD_W-1:0] head_ext;
  logic [7:0]        sr_byte;
  logic [7:0]        resp_byte;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign send       = (state == RD_RESP) && !tx_busy;
  assign pop        = send && (addr == ADDR_DOUTH) && !fifo_empty;
  // A pop in the same cycle frees a slot, so a push while full is still accepted
  assign push       = rpeak_valid && (!fifo_full || pop);
  assign drop       = rpeak_valid && fifo_full && !pop;
  assign head_ext   = HOLD_W'(fifo_mem[rd_ptr]);
  assign sr_byte    = {4'b0000, cmd_err, overflow, fifo_full, fifo_empty};

  always_comb begin
    resp_byte = 8'h00;
    case (addr)
      ADDR_SR:    resp_byte = sr_byte;
      ADDR_DOUTL: resp_byte = fifo_empty ? 8'h00 : head_ext[7:0];
      ADDR_DOUTM: resp_byte = hold[15:8];
      ADDR_DOUTH: resp_byte = hold[23:16];
      default:    resp_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= rpeak_loc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Flag clears from an SR read come first so any same-cycle set wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      addr          <= '0;
      dinl          <= '0;
      hold          <= '0;
      cmd_err       <= 1'b0;
      overflow      <= 1'b0;
      tx_data_valid <= 1'b0;
      tx_data       <= '0;
      sample_valid  <= 1'b0;
      sample_out    <= '0;
    end else begin
      tx_data_valid <= 1'b0;
      sample_valid  <= 1'b0;

      if (send && (addr == ADDR_SR)) begin
        cmd_err  <= 1'b0;
        overflow <= 1'b0;
      end
      if (drop) begin
        overflow <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (rx_data_valid) begin
            if (rx_data[7:4] != 4'h0) begin
              cmd_err <= 1'b1;
            end else begin
              addr  <= rx_data[3:1];
              state <= rx_data[0] ? WR_DATA : RD_RESP;
            end
          end
        end

        WR_DATA: begin
          if (rx_data_valid) begin
            if (addr == ADDR_DINL) begin
              dinl <= rx_data;
            end else if (addr == ADDR_DINH) begin
              sample_out   <= DATA_WIDTH'({rx_data[2:0], dinl}) - DATA_WIDTH'(DATA_OFFSET);
              sample_valid <= 1'b1;
            end
            state <= IDLE;
          end
        end

        RD_RESP: begin
          if (rx_data_valid) begin
            cmd_err <= 1'b1;
          end
          if (send) begin
            tx_data_valid <= 1'b1;
            tx_data       <= resp_byte;
            if (addr == ADDR_DOUTL) begin
              hold <= fifo_empty ? '0 : head_ext;
            end
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Self-checking bench for uart_reg_bridge: directed steps plus random traffic against a queue-based model.
module tb_uart_reg_bridge;

  logic               clk;
  logic               rst;
  logic               rx_data_valid;
  logic [7:0]         rx_data;
  logic               tx_busy;
  logic               tx_data_valid;
  logic [7:0]         tx_data;
  logic signed [10:0] sample_out;
  logic               sample_valid;
  logic [21:0]        rpeak_loc;
  logic               rpeak_valid;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  tx_q[$];
  logic [10:0] sample_q[$];

  // Reference model state
  int unsigned m_q[$];
  bit          m_cmd_err;
  bit          m_ovf;
  logic [7:0]  m_dinl;
  logic [23:0] m_hold;

  uart_reg_bridge dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data_valid (rx_data_valid),
    .rx_data       (rx_data),
    .tx_busy       (tx_busy),
    .tx_data_valid (tx_data_valid),
    .tx_data       (tx_data),
    .sample_out    (sample_out),
    .sample_valid  (sample_valid),
    .rpeak_loc     (rpeak_loc),
    .rpeak_valid   (rpeak_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (tx_data_valid) tx_q.push_back(tx_data);
    if (sample_valid) sample_q.push_back(sample_out);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    rx_data       = b;
    rx_data_valid = 1'b1;
    @(negedge clk);
    rx_data_valid = 1'b0;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_cmd_err = 1'b0;
    m_ovf     = 1'b0;
    m_dinl    = 8'h00;
    m_hold    = 24'h0;
  endtask

  task automatic model_push(input int unsigned v);
    if (m_q.size() == 8) m_ovf = 1'b1;
    else m_q.push_back(v);
  endtask

  task automatic model_read(input logic [2:0] a, output logic [7:0] e);
    e = 8'h00;
    case (a)
      3'd0: begin
        e = {4'b0, m_cmd_err, m_ovf, m_q.size() == 8, m_q.size() == 0};
        m_cmd_err = 1'b0;
        m_ovf     = 1'b0;
      end
      3'd3: begin
        m_hold = (m_q.size() == 0) ? 24'h0 : 24'(m_q[0]);
        e = m_hold[7:0];
      end
      3'd4: e = m_hold[15:8];
      3'd5: begin
        e = m_hold[23:16];
        if (m_q.size() != 0) void'(m_q.pop_front());
      end
      default: e = 8'h00;
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_tx_valid", 32'(tx_data_valid), 32'h0);
    checkOutput("rst_tx_data", 32'(tx_data), 32'h0);
    checkOutput("rst_sample_valid", 32'(sample_valid), 32'h0);
    checkOutput("rst_sample_out", 32'(sample_out), 32'h0);
    rst = 1'b0;
    model_reset();
    tx_q.delete();
    sample_q.delete();
  endtask

  task automatic wait_tx(output logic [7:0] b, output int lat);
    lat = 0;
    b   = 8'h00;
    while (tx_q.size() == 0 && lat < 40) begin
      @(negedge clk);
      rpeak_valid = 1'b0;
      lat++;
    end
    if (tx_q.size() == 0) checkOutput("tx_timeout", 32'h0, 32'h1);
    else b = tx_q.pop_front();
  endtask

  task automatic read_reg(input logic [2:0] a, input bit do_push, input int unsigned v);
    logic [7:0] e;
    logic [7:0] b;
    int lat;
    model_read(a, e);
    applyStimulus({4'b0, a, 1'b0});
    if (do_push) begin
      rpeak_loc   = 22'(v);
      rpeak_valid = 1'b1;
    end
    wait_tx(b, lat);
    if (do_push) model_push(v);
    checkOutput($sformatf("rd_data_a%0d", a), 32'(b), 32'(e));
    checkOutput("rd_latency", 32'(lat), 32'd1);
  endtask

  task automatic push_rpeak(input int unsigned v);
    @(negedge clk);
    rpeak_loc   = 22'(v);
    rpeak_valid = 1'b1;
    @(negedge clk);
    rpeak_valid = 1'b0;
    model_push(v);
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
    int raw;
    applyStimulus({4'b0, a, 1'b1});
    applyStimulus(d);
    @(negedge clk);
    if (a == 3'd2) begin
      raw = int'(d[2:0]) * 256 + int'(m_dinl);
      checkOutput("sample_pulses", 32'(sample_q.size()), 32'd1);
      if (sample_q.size() != 0)
        checkOutput("sample_value", 32'(sample_q.pop_front()), 32'((raw - 1024) & 'h7FF));
      sample_q.delete();
    end else begin
      if (a == 3'd1) m_dinl = d;
      checkOutput("no_sample", 32'(sample_q.size()), 32'd0);
    end
  endtask

  initial begin
    logic [7:0]  e;
    logic [7:0]  b;
    int unsigned v;
    int          op;

    rst           = 1'b0;
    rx_data_valid = 1'b0;
    rx_data       = 8'h00;
    tx_busy       = 1'b0;
    rpeak_loc     = '0;
    rpeak_valid   = 1'b0;
    model_reset();

    do_reset();
    read_reg(3'd0, 1'b0, 0);

    write_reg(3'd1, 8'hF3);
    write_reg(3'd2, 8'h03);
    for (int i = 0; i < 4; i++) begin
      write_reg(3'd1, 8'($urandom));
      write_reg(3'd2, 8'($urandom));
    end
    write_reg(3'd0, 8'hAA);
    write_reg(3'd6, 8'h55);

    push_rpeak(32'h2A5B3C);
    read_reg(3'd3, 1'b0, 0);
    read_reg(3'd4, 1'b0, 0);
    read_reg(3'd5, 1'b0, 0);
    read_reg(3'd0, 1'b0, 0);

    for (int i = 0; i < 9; i++) push_rpeak($urandom & 32'h3FFFFF);
    read_reg(3'd0, 1'b0, 0);
    read_reg(3'd0, 1'b0, 0);
    read_reg(3'd3, 1'b0, 0);
    read_reg(3'd4, 1'b0, 0);
    read_reg(3'd5, 1'b1, $urandom & 32'h3FFFFF);
    read_reg(3'd0, 1'b0, 0);
    for (int i = 0; i < 8; i++) begin
      read_reg(3'd3, 1'b0, 0);
      read_reg(3'd4, 1'b0, 0);
      read_reg(3'd5, 1'b0, 0);
    end
    read_reg(3'd3, 1'b0, 0);
    read_reg(3'd7, 1'b0, 0);

    tx_busy = 1'b1;
    applyStimulus(8'h00);
    applyStimulus(8'h55);
    m_cmd_err = 1'b1;
    model_read(3'd0, e);
    repeat (18) @(negedge clk);
    checkOutput("busy_no_tx", 32'(tx_q.size()), 32'd0);
    tx_busy = 1'b0;
    @(negedge clk);
    checkOutput("busy_release_cnt", 32'(tx_q.size()), 32'd1);
    if (tx_q.size() != 0) begin
      b = tx_q.pop_front();
      checkOutput("busy_release_data", 32'(b), 32'(e));
    end
    repeat (3) @(negedge clk);
    checkOutput("busy_single_tx", 32'(tx_q.size()), 32'd0);
    read_reg(3'd0, 1'b0, 0);

    applyStimulus(8'h90);
    m_cmd_err = 1'b1;
    read_reg(3'd0, 1'b0, 0);

    write_reg(3'd1, 8'h7C);
    applyStimulus(8'h05);
    do_reset();
    repeat (2) @(negedge clk);
    checkOutput("rst_no_sample", 32'(sample_q.size()), 32'd0);
    read_reg(3'd0, 1'b0, 0);
    write_reg(3'd2, 8'h06);

    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 3));
      case (op)
        0: push_rpeak($urandom & 32'h3FFFFF);
        1: read_reg(3'($urandom_range(0, 7)), 1'b0, 0);
        2: write_reg(3'($urandom_range(0, 7)), 8'($urandom));
        default: begin
          v = $urandom_range(16, 255);
          applyStimulus(8'(v));
          m_cmd_err = 1'b1;
        end
      endcase
    end
    read_reg(3'd0, 1'b0, 0);

    repeat (4) @(negedge clk);
    checkOutput("no_stray_tx", 32'(tx_q.size()), 32'd0);
    checkOutput("no_stray_sample", 32'(sample_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
